right_shift_two_places_buffered: RTL and testbench

- Inverse of the branch-offset left shifter: converts a byte offset/address (low two bits expected zero) back to a word offset by dropping the two LSBs.
- Sits between the address-generation stage and the instruction-memory word port.
- Registered valid/ready stage with a 2-entry skid buffer, alignment checking, and a saturating misalignment counter.

---
 rtl/right_shift_two_places_buffered_if.sv | 48 ++++
 rtl/right_shift_two_places_buffered.sv | 199 +++++++++++++++++++
 tb/tb_right_shift_two_places_buffered.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/right_shift_two_places_buffered_if.sv
// ---------------------------------------------------------------------------
// right_shift_two_places_buffered_if
//   Streaming bus between the address-generation stage and the word shifter.
//   It carries an upstream valid/ready leg (byte offset in) and a downstream
//   valid/ready leg (word offset plus misalignment flag out).
//
//   Parameters : IN_WIDTH - byte-offset width
//                SHIFT    - number of LSBs dropped on the way out
//   Signals    : in_data, in_valid, in_ready           (upstream leg)
//                out_data, out_misaligned, out_valid,
//                out_ready                             (downstream leg)
//   Modports   : slave  - the shifter block
//                master - the environment that feeds it and drains it
// ---------------------------------------------------------------------------
interface right_shift_two_places_buffered_if #(
    parameter int IN_WIDTH = 23,
    parameter int SHIFT    = 2
);
    localparam int OUT_WIDTH = IN_WIDTH - SHIFT;

    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_misaligned;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_misaligned,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_misaligned,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/right_shift_two_places_buffered.sv
// ---------------------------------------------------------------------------
// right_shift_two_places_buffered
//   Converts a byte offset back into a word offset by dropping the SHIFT
//   LSBs. The block is a registered valid/ready stage with a two-entry
//   buffer (main plus skid), so upstream sees no combinational path from
//   out_ready. Dropped bits that are non-zero mark the word as misaligned.
//   Such words are forwarded with a flag and counted in a saturating counter.
//
//   Optional feature (macro ALIGN_FAULT_HALT_EN):
//     defined   - accepting a misaligned word moves the block into FAULT.
//                 Input is then refused until fault_clr is pulsed. The
//                 buffer keeps draining downstream while in FAULT.
//     undefined - the block never leaves RUN. fault is tied 0 and
//                 fault_clr is ignored.
//
//   Ports:
//     clk          - rising-edge clock
//     rst_n        - asynchronous active-low reset
//     bus          - slave modport: in_data/in_valid/in_ready,
//                    out_data/out_misaligned/out_valid/out_ready
//     fault        - sticky alignment fault (FAULT state indicator)
//     fault_clr    - single-cycle pulse returning FAULT to RUN
//     misalign_cnt - saturating count of accepted misaligned inputs
// ---------------------------------------------------------------------------
module right_shift_two_places_buffered #(
    parameter int IN_WIDTH  = 23,
    parameter int SHIFT     = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    right_shift_two_places_buffered_if.slave  bus,
    output logic                              fault,
    input  logic                              fault_clr,
    output logic [CNT_WIDTH-1:0]              misalign_cnt
);
    localparam int OUT_WIDTH = IN_WIDTH - SHIFT;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // A word is misaligned when any of the dropped bits is set.
    function automatic logic misaligned_f(input logic [SHIFT-1:0] lsb);
        return (lsb != {SHIFT{1'b0}});
    endfunction

    logic [OUT_WIDTH-1:0] main_data_q, main_data_d;
    logic                 main_mis_q,  main_mis_d;
    logic                 main_vld_q,  main_vld_d;
    logic [OUT_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                 skid_mis_q,  skid_mis_d;
    logic                 skid_vld_q,  skid_vld_d;
    logic [0:0]           state_q,     state_d;
    logic                 ready_q,     ready_d;
    logic [CNT_WIDTH-1:0] cnt_q,       cnt_d;

    logic                 in_fire_s;
    logic                 out_fire_s;
    logic [OUT_WIDTH-1:0] in_word_s;
    logic                 in_mis_s;

    assign in_fire_s  = bus.in_valid && ready_q;
    assign out_fire_s = main_vld_q && bus.out_ready;
    assign in_word_s  = bus.in_data[IN_WIDTH-1:SHIFT];
    assign in_mis_s   = misaligned_f(bus.in_data[SHIFT-1:0]);

    // Buffer next state: main refills from skid first, else from the input.
    always_comb begin
        main_data_d = main_data_q;
        main_mis_d  = main_mis_q;
        main_vld_d  = main_vld_q;
        skid_data_d = skid_data_q;
        skid_mis_d  = skid_mis_q;
        skid_vld_d  = skid_vld_q;
        if (out_fire_s || !main_vld_q) begin
            // Main is free this cycle. While skid holds a word, in_ready is
            // low, so in_fire_s cannot be set at the same time.
            if (skid_vld_q) begin
                main_data_d = skid_data_q;
                main_mis_d  = skid_mis_q;
                main_vld_d  = 1'b1;
                skid_vld_d  = 1'b0;
            end else if (in_fire_s) begin
                main_data_d = in_word_s;
                main_mis_d  = in_mis_s;
                main_vld_d  = 1'b1;
            end else begin
                main_vld_d  = 1'b0;
            end
        end else begin
            // Main is stalled. An accepted word parks in the empty skid.
            if (in_fire_s) begin
                skid_data_d = in_word_s;
                skid_mis_d  = in_mis_s;
                skid_vld_d  = 1'b1;
            end else begin
                skid_vld_d  = skid_vld_q;
            end
        end
    end

    // Saturating misalignment counter; it holds at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (in_fire_s && in_mis_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

`ifdef ALIGN_FAULT_HALT_EN
    logic fault_q, fault_d;

    // RUN/FAULT sequencing: a misaligned accept halts input until cleared.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (in_fire_s && in_mis_s) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: state_d = ST_RUN;
        endcase
        fault_d = (state_d == ST_FAULT);
    end

    // Fault flag register, kept in step with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    logic unused_fault_clr_s;

    // Without the halt feature the block never leaves RUN.
    always_comb begin
        state_d = ST_RUN;
    end

    assign unused_fault_clr_s = fault_clr;
    assign fault              = 1'b0;
`endif

    // in_ready is registered from next state, so it rises on the first
    // edge after reset is released.
    always_comb begin
        ready_d = !skid_vld_d && (state_d == ST_RUN);
    end

    // State registers; an asynchronous reset discards every buffered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= {OUT_WIDTH{1'b0}};
            main_mis_q  <= 1'b0;
            main_vld_q  <= 1'b0;
            skid_data_q <= {OUT_WIDTH{1'b0}};
            skid_mis_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            state_q     <= ST_RUN;
            ready_q     <= 1'b0;
            cnt_q       <= {CNT_WIDTH{1'b0}};
        end else begin
            main_data_q <= main_data_d;
            main_mis_q  <= main_mis_d;
            main_vld_q  <= main_vld_d;
            skid_data_q <= skid_data_d;
            skid_mis_q  <= skid_mis_d;
            skid_vld_q  <= skid_vld_d;
            state_q     <= state_d;
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready       = ready_q;
    assign bus.out_data       = main_data_q;
    assign bus.out_misaligned = main_mis_q;
    assign bus.out_valid      = main_vld_q;
    assign misalign_cnt       = cnt_q;

endmodule

// File: tb/tb_right_shift_two_places_buffered.sv
// ---------------------------------------------------------------------------
// tb_right_shift_two_places_buffered
//   Directed bench for the byte-to-word offset shifter. u0 uses the default
//   parameters. u1 uses CNT_WIDTH=2 to exercise counter saturation.
//   Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_right_shift_two_places_buffered;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       fault0, fault1;
    logic       fault_clr0, fault_clr1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    right_shift_two_places_buffered_if #(.IN_WIDTH(23), .SHIFT(2)) bus0 ();
    right_shift_two_places_buffered_if #(.IN_WIDTH(23), .SHIFT(2)) bus1 ();

    right_shift_two_places_buffered #(.IN_WIDTH(23), .SHIFT(2), .CNT_WIDTH(8)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .fault(fault0), .fault_clr(fault_clr0), .misalign_cnt(cnt0)
    );

    right_shift_two_places_buffered #(.IN_WIDTH(23), .SHIFT(2), .CNT_WIDTH(2)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .fault(fault1), .fault_clr(fault_clr1), .misalign_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.in_data = 23'h0; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_data = 23'h0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
        fault_clr0 = 1'b0; fault_clr1 = 1'b0;
        #3;
        chk("rst_out_valid", 32'(bus0.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus0.out_data), 32'h0);
        chk("rst_out_mis", 32'(bus0.out_misaligned), 32'h0);
        chk("rst_fault", 32'(fault0), 32'h0);
        chk("rst_cnt", 32'(cnt0), 32'h0);
        #19 rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(bus0.in_ready), 32'h1);

        // Single aligned word.
        bus0.out_ready = 1'b1;
        bus0.in_data = 23'h000104; bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        chk("single_valid", 32'(bus0.out_valid), 32'h1);
        chk("single_data", 32'(bus0.out_data), 32'h41);
        chk("single_mis", 32'(bus0.out_misaligned), 32'h0);
        chk("single_cnt", 32'(cnt0), 32'h0);
        step();
        chk("single_drained", 32'(bus0.out_valid), 32'h0);

        // Back-pressure: main, then skid, then the third word is refused.
        bus0.out_ready = 1'b0;
        bus0.in_data = 23'h000008; bus0.in_valid = 1'b1;
        step();
        chk("bp_ready_after1", 32'(bus0.in_ready), 32'h1);
        bus0.in_data = 23'h00000C;
        step();
        chk("bp_ready_after2", 32'(bus0.in_ready), 32'h0);
        chk("bp_head_data", 32'(bus0.out_data), 32'h2);
        bus0.in_data = 23'h000010;
        step();
        chk("bp_stall_ready", 32'(bus0.in_ready), 32'h0);
        chk("bp_stall_data", 32'(bus0.out_data), 32'h2);
        chk("bp_stall_valid", 32'(bus0.out_valid), 32'h1);
        bus0.out_ready = 1'b1;
        step();
        chk("bp_second_data", 32'(bus0.out_data), 32'h3);
        chk("bp_ready_back", 32'(bus0.in_ready), 32'h1);
        step();
        bus0.in_valid = 1'b0;
        chk("bp_third_data", 32'(bus0.out_data), 32'h4);
        chk("bp_third_valid", 32'(bus0.out_valid), 32'h1);
        step();
        chk("bp_no_dup", 32'(bus0.out_valid), 32'h0);

        // Misaligned word.
        bus0.in_data = 23'h000006; bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        chk("mis_data", 32'(bus0.out_data), 32'h1);
        chk("mis_flag", 32'(bus0.out_misaligned), 32'h1);
        chk("mis_cnt", 32'(cnt0), 32'h1);
`ifdef ALIGN_FAULT_HALT_EN
        chk("mis_fault", 32'(fault0), 32'h1);
        chk("mis_ready", 32'(bus0.in_ready), 32'h0);
        step();
        fault_clr0 = 1'b1;
        step();
        fault_clr0 = 1'b0;
        chk("clr_fault", 32'(fault0), 32'h0);
        chk("clr_ready", 32'(bus0.in_ready), 32'h1);

        // Halt on misaligned input; a held aligned word waits for the clear.
        bus0.in_data = 23'h000003; bus0.in_valid = 1'b1;
        step();
        chk("halt_fault", 32'(fault0), 32'h1);
        chk("halt_ready", 32'(bus0.in_ready), 32'h0);
        chk("halt_mis", 32'(bus0.out_misaligned), 32'h1);
        chk("halt_data", 32'(bus0.out_data), 32'h0);
        bus0.in_data = 23'h000020;
        step();
        step();
        chk("halt_hold_ready", 32'(bus0.in_ready), 32'h0);
        chk("halt_hold_fault", 32'(fault0), 32'h1);
        chk("halt_drained", 32'(bus0.out_valid), 32'h0);
        chk("halt_cnt", 32'(cnt0), 32'h2);
        fault_clr0 = 1'b1;
        step();
        fault_clr0 = 1'b0;
        chk("halt_clr_fault", 32'(fault0), 32'h0);
        chk("halt_clr_ready", 32'(bus0.in_ready), 32'h1);
        step();
        bus0.in_valid = 1'b0;
        chk("halt_resume_valid", 32'(bus0.out_valid), 32'h1);
        chk("halt_resume_data", 32'(bus0.out_data), 32'h8);
        step();
`else
        chk("mis_fault", 32'(fault0), 32'h0);
        chk("mis_ready", 32'(bus0.in_ready), 32'h1);
        fault_clr0 = 1'b1;
        step();
        fault_clr0 = 1'b0;
        chk("clr_ignored_fault", 32'(fault0), 32'h0);
        chk("clr_ignored_ready", 32'(bus0.in_ready), 32'h1);
`endif

        // Saturation on the 2-bit counter instance.
        for (int i = 0; i < 5; i++) begin
            bus1.in_data = 23'h000001; bus1.in_valid = 1'b1;
            step();
            bus1.in_valid = 1'b0;
            chk($sformatf("sat_cnt_%0d", i), 32'(cnt1), (i < 3) ? 32'(i + 1) : 32'h3);
            fault_clr1 = 1'b1;
            step();
            fault_clr1 = 1'b0;
        end

        // Reset mid-stream with both entries occupied.
        bus0.out_ready = 1'b0;
        bus0.in_data = 23'h000040; bus0.in_valid = 1'b1;
        step();
        bus0.in_data = 23'h000044;
        step();
        bus0.in_valid = 1'b0;
        chk("full_ready", 32'(bus0.in_ready), 32'h0);
        chk("full_valid", 32'(bus0.out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus0.out_valid), 32'h0);
        chk("async_cnt", 32'(cnt0), 32'h0);
        chk("async_cnt1", 32'(cnt1), 32'h0);
        step();
        #2 rst_n = 1'b1;
        bus0.out_ready = 1'b1;
        step();
        chk("post_rst_ready", 32'(bus0.in_ready), 32'h1);
        chk("post_rst_valid", 32'(bus0.out_valid), 32'h0);
        step();
        chk("post_rst_no_stale", 32'(bus0.out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
